s27_pattern_gen: RTL and testbench
==================================

S27_PATTERN_GEN -- requirements
Module: s27_pattern_gen

Interface
REQ-001 Parameter LFSR_W, default 16, LFSR and MISR width; only 16 is supported.
REQ-002 Parameter CNT_W, default 16, width of the pattern counter.
REQ-003 Parameter DEFAULT_SEED, default 16'hACE1, seed used when seed_in is zero.
REQ-004 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-low reset.
REQ-006 Port start, input, 1, begin a run; sampled in IDLE only.
REQ-007 Port abort, input, 1, terminate the run; returns to IDLE.
REQ-008 Port num_patterns, input, CNT_W, number of patterns per run; sampled on start.
REQ-009 Port seed_in, input, 16, LFSR seed; sampled on start.
REQ-010 Port pat_data, output, 4, stimulus vector driving the downstream s27 `in` bus.
REQ-011 Port pat_valid, output, 1, pat_data holds a valid pattern.
REQ-012 Port pat_ready, input, 1, downstream accepts pat_data this cycle.
REQ-013 Port resp_in, input, 1, s27 `out` bit, sampled on each accepted pattern.
REQ-014 Port busy, output, 1, high in RUN.
REQ-015 Port done, output, 1, single-cycle pulse at run completion.
REQ-016 Port sig_out, output, 16, MISR signature; stable from the done pulse until the next start.
REQ-017 Port pat_count, output, CNT_W, number of patterns accepted in the current or last run.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 IDLE & start & num_patterns!=0 -> RUN; IDLE & start & num_patterns==0 -> DONE.
REQ-020 On start, the LFSR SHALL load seed_in, or DEFAULT_SEED when seed_in==0; pat_count and the MISR SHALL clear to 0.
REQ-021 The LFSR is Fibonacci, shift-left: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
REQ-022 pat_data SHALL equal lfsr[3:0]; pat_valid SHALL be 1 exactly in RUN.
REQ-023 Handshake: accept = pat_valid & pat_ready. On accept the LFSR advances and pat_count increments; otherwise both hold and pat_data stays stable.
REQ-024 An accept where pat_count==num_patterns-1 SHALL move the FSM to DONE; no further accept occurs in that run.
REQ-025 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-026 abort in RUN or DONE SHALL go to IDLE on the next edge with no done pulse; pat_count and sig_out hold their values.
REQ-027 abort and start asserted together in IDLE: abort wins and the FSM stays in IDLE.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 pat_count SHALL not wrap, because a run ends at num_patterns; the maximum is 2^CNT_W-1.

Reset
REQ-030 reset==0 at a clk edge SHALL force: IDLE, LFSR=DEFAULT_SEED, pat_count=0, MISR=0, pat_valid=0, busy=0, done=0.
REQ-031 Reset mid-run SHALL abandon the run without a done pulse; pat_data SHALL read DEFAULT_SEED[3:0]=4'h1 after reset.

Configuration
REQ-032 Macro PATGEN_MISR_EN defined: on each accept, MISR next = {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]} ^ {15'b0, resp_in}, and sig_out = MISR.
REQ-033 Macro PATGEN_MISR_EN undefined: no MISR register; sig_out is tied to 0; resp_in is present but ignored.

Structure
REQ-034 Shared package s27_tb_pkg SHALL hold the FSM state enum, LFSR/MISR tap constants and DEFAULT_SEED.
REQ-035 One sub-module, s27_lfsr16 (load, advance, seed, value), SHALL be instantiated for the LFSR and, when the macro is defined, for the MISR (with a serial xor input).

Verification
REQ-036 seed_in=16'h0001, num_patterns=5, pat_ready=1: pat_data sequence 1,2,4,8,0; done pulses one cycle after the 5th accept; pat_count=5.
REQ-037 Same run with pat_ready toggling 1,0,1,0: pat_data holds during ready=0; the same 5-value sequence results; done is delayed accordingly.
REQ-038 seed_in=0: the first pat_data is 4'h1 (from DEFAULT_SEED 16'hACE1); num_patterns=0 with start gives done on the next cycle and busy never rises.
REQ-039 abort after 2 accepts of a 10-pattern run: IDLE on the next edge, no done pulse, pat_count=2; reset mid-run gives the same outcome plus pat_count=0.
REQ-040 With PATGEN_MISR_EN, seed 16'h0001, 4 patterns, resp_in=1 on every accept: sig_out=16'h000F at done; without the macro, sig_out=0.

Source files
------------

// File: rtl/s27_pattern_gen_pkg.sv
// Shared types and constants for the s27 pattern generator: FSM states, LFSR/MISR taps, default seed.
package s27_tb_pkg;

  localparam int unsigned LFSR16_W = 16;
  localparam int unsigned PAT_W    = 4;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [LFSR16_W-1:0] TAP_MASK     = 16'hB400;
  localparam logic [LFSR16_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One shift-left Fibonacci step.
  function automatic logic [LFSR16_W-1:0] lfsr_step(input logic [LFSR16_W-1:0] v);
    return {v[LFSR16_W-2:0], ^(v & TAP_MASK)};
  endfunction

endpackage

// File: rtl/s27_pattern_gen_if.sv
// Pattern stimulus/response bus between the generator and the downstream s27 block.
interface s27_pattern_gen_if;
  import s27_tb_pkg::*;

  logic [PAT_W-1:0] pat_data;
  logic             pat_valid;
  logic             pat_ready;
  logic             resp_in;

  modport master (output pat_data, output pat_valid, input pat_ready, input resp_in);
  modport slave  (input pat_data, input pat_valid, output pat_ready, output resp_in);

endinterface

// File: rtl/s27_pattern_gen_lfsr16.sv
// 16-bit Fibonacci shift register with synchronous load and an optional serial xor input (MISR use).
module s27_lfsr16
  import s27_tb_pkg::*;
#(
  parameter logic [LFSR16_W-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                advance,
  input  logic [LFSR16_W-1:0] seed,
  input  logic                sin,
  output logic [LFSR16_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= seed;
    end else if (advance) begin
      value <= lfsr_step(value) ^ {{(LFSR16_W-1){1'b0}}, sin};
    end
  end

endmodule

// File: rtl/s27_pattern_gen.sv
// LFSR pattern generator for the s27 block with handshake and run control.
// Define PATGEN_MISR_EN to compact resp_in into a MISR signature on sig_out.
module s27_pattern_gen
  import s27_tb_pkg::*;
#(
  parameter int unsigned   LFSR_W       = 16,
  parameter int unsigned   CNT_W        = 16,
  parameter logic [15:0]   DEFAULT_SEED = s27_tb_pkg::DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     num_patterns,
  input  logic [15:0]          seed_in,
  s27_pattern_gen_if.master    pb,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          sig_out,
  output logic [CNT_W-1:0]     pat_count
);

  state_t             state_q, state_d;
  logic               load;
  logic               accept;
  logic               last;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   count_q;
  logic [LFSR_W-1:0]  seed_sel;
  logic [LFSR_W-1:0]  lfsr_q;
  logic               unused_lfsr_hi;

  // An abort cycle never counts as an accept so pat_count holds its value.
  assign accept   = (state_q == RUN) & pb.pat_ready & ~abort;
  assign last     = (count_q == num_q - CNT_W'(1));
  assign seed_sel = (seed_in == 16'h0) ? DEFAULT_SEED : seed_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        count_q <= '0;
        num_q   <= num_patterns;
      end else if (accept) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          load    = 1'b1;
          state_d = (num_patterns == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept && last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  s27_lfsr16 #(.RESET_VAL(DEFAULT_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (accept),
    .seed    (seed_sel),
    .sin     (1'b0),
    .value   (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:PAT_W];

  assign pb.pat_data  = lfsr_q[PAT_W-1:0];
  assign pb.pat_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign pat_count    = count_q;

`ifdef PATGEN_MISR_EN
  logic [LFSR_W-1:0] misr_q;

  s27_lfsr16 #(.RESET_VAL(16'h0000)) u_misr (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (accept),
    .seed    (16'h0000),
    .sin     (pb.resp_in),
    .value   (misr_q)
  );

  assign sig_out = misr_q;
`else
  logic unused_resp;

  assign unused_resp = pb.resp_in;
  assign sig_out     = 16'h0000;
`endif

endmodule

// File: tb/tb_s27_pattern_gen.sv
// Directed bench for s27_pattern_gen with a cycle-level reference model checked every cycle.
module tb_s27_pattern_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_patterns = 16'h0;
  logic [15:0] seed_in = 16'h0;
  logic        busy, done;
  logic [15:0] sig_out, pat_count;

  int checks = 0;
  int failures = 0;

  s27_pattern_gen_if pb();

  s27_pattern_gen dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .num_patterns (num_patterns),
    .seed_in      (seed_in),
    .pb           (pb),
    .busy         (busy),
    .done         (done),
    .sig_out      (sig_out),
    .pat_count    (pat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] step16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference model: compares at negedge, then advances on the inputs the next posedge will sample.
  bit          m_valid = 0;
  bit          m_active = 0;
  bit          m_done = 0;
  logic [15:0] m_lfsr, m_misr, m_count, m_num;

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("busy", 32'(busy), 32'(m_active));
        check("pat_valid", 32'(pb.pat_valid), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("pat_data", 32'(pb.pat_data), 32'(m_lfsr[3:0]));
        check("pat_count", 32'(pat_count), 32'(m_count));
`ifdef PATGEN_MISR_EN
        check("sig_out", 32'(sig_out), 32'(m_misr));
`else
        check("sig_out", 32'(sig_out), 32'h0);
`endif
      end
      if (!reset) begin
        m_valid = 1; m_active = 0; m_done = 0;
        m_lfsr = 16'hACE1; m_misr = 16'h0; m_count = 16'h0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_active) begin
        if (abort) begin
          m_active = 0;
        end else if (pb.pat_ready) begin
          m_lfsr  = step16(m_lfsr);
          m_misr  = step16(m_misr) ^ {15'b0, pb.resp_in};
          m_count = m_count + 16'd1;
          if (m_count == m_num) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end else if (start && !abort) begin
        m_lfsr  = (seed_in == 16'h0) ? 16'hACE1 : seed_in;
        m_misr  = 16'h0;
        m_count = 16'h0;
        m_num   = num_patterns;
        if (num_patterns == 16'h0) m_done = 1;
        else m_active = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] acc_q[$];
  int         run_cycles;
  bit         busy_seen;

  // Start a run and collect accepted patterns until done; ready_mode 1 toggles ready 1,0,1,0.
  task automatic do_run(input logic [15:0] seed, input logic [15:0] n, input int ready_mode);
    bit got_done = 0;
    acc_q.delete();
    busy_seen  = 0;
    run_cycles = -1;
    seed_in = seed; num_patterns = n; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        got_done   = 1;
        run_cycles = c;
        break;
      end
      if (busy) busy_seen = 1;
      pb.pat_ready = (ready_mode == 1) ? (c % 2 == 0) : 1'b1;
      if (pb.pat_valid && pb.pat_ready) acc_q.push_back(pb.pat_data);
      tick();
    end
    pb.pat_ready = 1'b0;
    check("run_done_timeout", 32'(got_done), 32'd1);
  endtask

  logic [3:0] exp_seq[5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0};

  initial begin
    pb.pat_ready = 1'b0;
    pb.resp_in   = 1'b1;
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pat_data", 32'(pb.pat_data), 32'h1);
    check("rst_pat_count", 32'(pat_count), 32'd0);
    check("rst_sig", 32'(sig_out), 32'h0);
    reset = 1'b1;
    tick();

    do_run(16'h0001, 16'd5, 0);
    check("t1_cycles", 32'(run_cycles), 32'd5);
    check("t1_len", 32'(acc_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < acc_q.size(); i++) check("t1_seq", 32'(acc_q[i]), 32'(exp_seq[i]));
    check("t1_count", 32'(pat_count), 32'd5);
`ifdef PATGEN_MISR_EN
    check("t1_sig", 32'(sig_out), 32'h001F);
`else
    check("t1_sig", 32'(sig_out), 32'h0);
`endif
    tick();

    do_run(16'h0001, 16'd5, 1);
    check("t2_cycles", 32'(run_cycles), 32'd9);
    check("t2_len", 32'(acc_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < acc_q.size(); i++) check("t2_seq", 32'(acc_q[i]), 32'(exp_seq[i]));
    check("t2_count", 32'(pat_count), 32'd5);
    tick();

    do_run(16'h0000, 16'd3, 0);
    check("t3_len", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() >= 2) begin
      check("t3_first", 32'(acc_q[0]), 32'h1);
      check("t3_second", 32'(acc_q[1]), 32'h3);
    end
    tick();

    do_run(16'h0001, 16'd0, 0);
    check("t4_cycles", 32'(run_cycles), 32'd0);
    check("t4_busy_seen", 32'(busy_seen), 32'd0);
    check("t4_count", 32'(pat_count), 32'd0);
    tick();

    do_run(16'h0001, 16'd4, 0);
`ifdef PATGEN_MISR_EN
    check("t5_sig", 32'(sig_out), 32'h000F);
`else
    check("t5_sig", 32'(sig_out), 32'h0);
`endif
    tick();

    // Abort after two accepts; a start mid-run must be ignored.
    seed_in = 16'h0001; num_patterns = 16'd10; start = 1'b1; pb.pat_ready = 1'b1;
    tick();
    start = 1'b1; seed_in = 16'h8000;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1; pb.pat_ready = 1'b0;
    tick();
    abort = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_count", 32'(pat_count), 32'd2);
    check("t6_pat_data", 32'(pb.pat_data), 32'h4);
    tick();
    check("t6_no_done", 32'(done), 32'd0);

    // Abort and start together in IDLE: stay idle.
    seed_in = 16'h0001; num_patterns = 16'd5; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_done", 32'(done), 32'd0);
    tick();

    // Reset mid-run.
    seed_in = 16'h0001; num_patterns = 16'd10; start = 1'b1; pb.pat_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("t8_pre_count", 32'(pat_count), 32'd3);
    reset = 1'b0;
    tick();
    reset = 1'b1; pb.pat_ready = 1'b0;
    check("t8_busy", 32'(busy), 32'd0);
    check("t8_count", 32'(pat_count), 32'd0);
    check("t8_pat_data", 32'(pb.pat_data), 32'h1);
    check("t8_done", 32'(done), 32'd0);
    tick();
    check("t8_no_done", 32'(done), 32'd0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
